// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the venera_cpu_1 front end: the instruction word layout
// and helpers used by the fetch unit and its consumers.
package instruction_fetch_pkg;

  localparam int unsigned OPCODE_WIDTH  = 8;
  localparam int unsigned OPERAND_WIDTH = 8;
  localparam int unsigned INSTR_WIDTH   = OPCODE_WIDTH + OPERAND_WIDTH;

  typedef struct packed {
    logic [OPCODE_WIDTH-1:0]  opcode;
    logic [OPERAND_WIDTH-1:0] operand;
  } instr_t;

  // Driven on the instruction bus whenever no instruction is being issued.
  localparam instr_t INSTR_BUBBLE = '0;

  function automatic instr_t pack_instr(input logic [OPCODE_WIDTH-1:0]  opcode,
                                        input logic [OPERAND_WIDTH-1:0] operand);
    instr_t w;
    w.opcode  = opcode;
    w.operand = operand;
    return w;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Fetch unit: holds the pc, reads words from a synchronous ROM and issues them as
// one-cycle pulses, spaced so a controller jump lands before the next fetch.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           ISSUE_GAP  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  output logic                  o_imem_rd,
  output logic [ADDR_WIDTH-1:0] o_imem_address,
  input  logic [15:0]           i_imem_data,
  output logic                  o_instruction_valid,
  output logic [15:0]           o_instruction,
  input  logic                  i_valid_set_address_instruction,
  input  logic [ADDR_WIDTH-1:0] i_value_set_address_instruction,
  output logic [ADDR_WIDTH-1:0] o_pc
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_READ  = 4'd1;
  localparam logic [3:0] S_WAIT  = 4'd2;
  localparam logic [3:0] S_ISSUE = 4'd3;
  localparam logic [3:0] S_GAP   = 4'd4;

  localparam int unsigned           ISSUE_GAP_MIN = 2;
  localparam logic [3:0]            GAP_LOAD      = 4'(ISSUE_GAP);
  localparam logic [3:0]            GAP_ONE       = 4'd1;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP       = 1;

  if (ISSUE_GAP < ISSUE_GAP_MIN || ISSUE_GAP > 15) begin : g_bad_issue_gap
    $error("ISSUE_GAP must be in 2..15");
  end

  logic [3:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [3:0]            gap_cnt_q, gap_cnt_d;
  logic                  flush_q, flush_d;
  logic                  imem_rd_q;
  logic [ADDR_WIDTH-1:0] imem_address_q;
  logic                  instr_valid_q;
  instr_t                instr_q;
  logic                  jump;

  assign jump = i_valid_set_address_instruction;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    gap_cnt_d = gap_cnt_q;
    flush_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_enable) state_d = S_READ;
      end
      S_READ: begin
        // A jump here invalidates the read already issued to the ROM.
        state_d = S_WAIT;
        flush_d = jump;
      end
      S_WAIT: begin
        state_d = (flush_q || jump) ? S_READ : S_ISSUE;
      end
      S_ISSUE: begin
        pc_d      = pc_q + PC_STEP;
        gap_cnt_d = GAP_LOAD;
        state_d   = S_GAP;
      end
      S_GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_ONE;
        if (gap_cnt_q == GAP_ONE) state_d = i_enable ? S_READ : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Jump target overrides the post-issue increment.
    if (jump) pc_d = i_value_set_address_instruction;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q        <= S_IDLE;
      pc_q           <= RESET_ADDR;
      gap_cnt_q      <= '0;
      flush_q        <= 1'b0;
      imem_rd_q      <= 1'b0;
      imem_address_q <= '0;
      instr_valid_q  <= 1'b0;
      instr_q        <= INSTR_BUBBLE;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      gap_cnt_q      <= gap_cnt_d;
      flush_q        <= flush_d;
      imem_rd_q      <= (state_d == S_READ);
      imem_address_q <= (state_d == S_READ) ? pc_d : '0;
      instr_valid_q  <= (state_d == S_ISSUE);
      instr_q        <= (state_d == S_ISSUE) ? instr_t'(i_imem_data) : INSTR_BUBBLE;
    end
  end

  assign o_imem_rd           = imem_rd_q;
  assign o_imem_address      = imem_address_q;
  assign o_instruction_valid = instr_valid_q;
  assign o_instruction       = instr_q;
  assign o_pc                = pc_q;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Front end of the venera_cpu_1 core.
- Holds the program counter and reads 16-bit instruction words from a synchronous instruction ROM.
- Issues each word to the controller as a one-cycle instruction-bus pulse.
- Accepts the controller's set-address (jump) bus, which redirects the program counter.
- Paces issue so that any jump resulting from an instruction is taken before the next fetch.

Parameters:
- ADDR_WIDTH, 8: program counter / ROM address width.
- ISSUE_GAP, 4: cycles spent in S_GAP after each issue. Legal range is 2..15; values below 2 are illegal.
- RESET_ADDR, 8'h00: program counter value after reset.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  run request; sampled only in S_IDLE and at the end of S_GAP.
- o_imem_rd  out  1  ROM read strobe, one cycle.
- o_imem_address  out  ADDR_WIDTH  ROM word address.
- i_imem_data  in  16  ROM data; valid in the cycle after o_imem_rd.
- o_instruction_valid  out  1  instruction pulse to the controller.
- o_instruction  out  16  {opcode[15:8], operand[7:0]}; 0 whenever valid is low.
- i_valid_set_address_instruction  in  1  jump request from the controller.
- i_value_set_address_instruction  in  ADDR_WIDTH  jump target.
- o_pc  out  ADDR_WIDTH  current program counter (debug).

Behaviour:
- Reset (synchronous, active-high, on i_clk; wins over everything, including mid-fetch):
  - state = S_IDLE, pc = RESET_ADDR, gap counter = 0.
  - o_imem_rd = 0, o_imem_address = 0, o_instruction_valid = 0, o_instruction = 0.
  - All outputs are registered.
- States: S_IDLE, S_READ, S_WAIT, S_ISSUE, S_GAP (4-bit encoding, local to the module).
- S_IDLE:
  - o_imem_rd = 0.
  - If i_enable = 1, go to S_READ next cycle.
- S_READ (1 cycle):
  - o_imem_rd = 1, o_imem_address = pc.
  - Go to S_WAIT.
- S_WAIT (1 cycle):
  - o_imem_rd = 0, o_imem_address = 0.
  - i_imem_data is captured at the end of this cycle.
  - Go to S_ISSUE.
- S_ISSUE (1 cycle):
  - o_instruction_valid = 1, o_instruction = captured word.
  - pc <= pc + 1, modulo 2^ADDR_WIDTH (8'hFF wraps to 8'h00).
  - Gap counter is loaded with ISSUE_GAP.
  - Go to S_GAP.
- S_GAP:
  - o_instruction_valid = 0, o_instruction = 0.
  - The counter decrements each cycle.
  - On the cycle it reaches 1: go to S_READ if i_enable = 1, else S_IDLE.
- Timing:
  - The controller's jump response appears 2 cycles after o_instruction_valid, so ISSUE_GAP >= 2 guarantees the next fetch uses the jump target.
  - Issue period is 3 + ISSUE_GAP cycles (7 at default).
  - First valid is 3 cycles after the cycle in which i_enable is sampled high in S_IDLE.
- Jump handling (i_valid_set_address_instruction = 1), in any non-reset state:
  - pc <= i_value_set_address_instruction.
  - In S_ISSUE, the jump wins over the +1 increment.
  - In S_WAIT, the fetched word is discarded (flush): no valid pulse; the next state is S_READ at the new pc.
  - In S_READ, the in-flight read is also discarded: S_WAIT then S_READ again at the new pc.
  - In S_IDLE or S_GAP: pc update only; the state flow is unchanged.
- i_enable dropping mid-fetch: the current instruction completes, including its issue and gap; then the block returns to S_IDLE. No partial reads occur.
- o_pc reflects the pc register at all times.

Decomposition:
- State encodings and the ISSUE_GAP minimum are local parameters inside the module.
- The instruction word layout ({opcode, operand}, 8+8 bits) belongs in the shared include alongside the opcode definitions.
- No sub-module: the design is a single FSM plus the pc register and the gap counter.

Test Plan:
1. Reset, ROM[0..3] = 16'h0101, 16'h0202, 16'h0303, 16'h0404; raise i_enable at cycle 0.
   - o_instruction_valid pulses at cycles 3, 10, 17, 24.
   - The words appear in order; o_pc steps 1, 2, 3, 4.
2. Two cycles after the valid pulse for the word at address 2, drive the jump bus with value 8'h40.
   - The next o_imem_rd has o_imem_address = 8'h40.
   - Address 3 is never read.
3. Jump to 8'hFF, ROM[8'hFF] = 16'h0A0A.
   - 16'h0A0A is issued.
   - The next read address is 8'h00 (wrap).
4. Drive a jump to 8'h20 during S_WAIT.
   - No valid pulse for that fetch.
   - The next cycle is S_READ with o_imem_address = 8'h20.
5. Drop i_enable during S_WAIT.
   - The instruction is still issued.
   - The gap completes, then no further o_imem_rd; the block sits in S_IDLE.
6. Assert i_reset during S_ISSUE with pc = 8'h05.
   - Next cycle: all outputs 0, o_pc = RESET_ADDR, state S_IDLE.
